// File: rtl/fir_transposed_pipe_if.sv
// fir_transposed_pipe_if: sample stream, coefficient load and result bundle.
// master drives din/flush/coef_*; slave (the filter) drives dout/sat_flag.
interface fir_transposed_pipe_if #(
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int CW   = 16
);
    localparam int AB = $clog2(TAPS);

    logic                 din_valid;
    logic signed [DW-1:0] din;
    logic                 flush;
    logic                 coef_wr;
    logic [AB-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 coef_commit;
    logic                 dout_valid;
    logic signed [DW-1:0] dout;
    logic                 sat_flag;

    modport master (
        output din_valid, din, flush,
        output coef_wr, coef_addr, coef_data, coef_commit,
        input  dout_valid, dout, sat_flag
    );

    modport slave (
        input  din_valid, din, flush,
        input  coef_wr, coef_addr, coef_data, coef_commit,
        output dout_valid, dout, sat_flag
    );
endinterface

// File: rtl/fir_transposed_pipe.sv
// fir_transposed_pipe: 3-stage transposed-form FIR, double-buffered coefs.
// Ports: clk, rst (async, active-high), bus (slave): din_valid/din/flush in,
// coef_wr/coef_addr/coef_data/coef_commit in, dout_valid/dout/sat_flag out.
// Macro FIR_SAT_EN: clamp output and raise sticky sat_flag; else wrap.
module fir_transposed_pipe #(
    parameter int TAPS  = 16,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int SHIFT = 15
) (
    input  logic                clk,
    input  logic                rst,
    fir_transposed_pipe_if.slave bus
);
    localparam int AB = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int AW = PW + AB;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [AW:0] RND =
        (SHIFT > 0) ? ((AW+1)'(1) << RS) : (AW+1)'(0);

    logic signed [DW-1:0] x_r;
    logic                 v1;
    logic                 v2;
    logic signed [CW-1:0] shadow [TAPS];
    logic signed [CW-1:0] act    [TAPS];
    logic signed [PW-1:0] prod   [TAPS];
    logic signed [AW-1:0] pext   [TAPS];
    logic signed [AW-1:0] carry  [TAPS];
    logic signed [AW-1:0] acc    [TAPS];
    logic [TAPS-1:0]      wr_hit;
    logic signed [AW:0]   rsum;
    logic signed [AW:0]   y;
    logic signed [DW-1:0] y_fmt;
    logic signed [DW-1:0] dout_r;
    logic                 dv_r;

    // Out-of-range addresses match no tap, so they are dropped silently.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            wr_hit[k] = bus.coef_wr && (bus.coef_addr == AB'(k));
        end
    end

    // Commit copies shadow, taking a same-edge write straight through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                act[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (wr_hit[k]) begin
                    shadow[k] <= bus.coef_data;
                end
                if (bus.coef_commit) begin
                    act[k] <= wr_hit[k] ? bus.coef_data : shadow[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= '0;
            v1  <= 1'b0;
        end else if (bus.flush) begin
            x_r <= '0;
            v1  <= 1'b0;
        end else if (bus.din_valid) begin
            x_r <= bus.din;
            v1  <= 1'b1;
        end else begin
            v1  <= 1'b0;
        end
    end

    // Each tap adds its product to the partial sum of the next tap;
    // the last tap has no successor and starts a fresh sum.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod[k]  = x_r * act[k];
            pext[k]  = {{AB{prod[k][PW-1]}}, prod[k]};
            carry[k] = '0;
        end
        for (int k = 0; k < TAPS - 1; k++) begin
            carry[k] = acc[k+1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                acc[k] <= '0;
            end
            v2 <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < TAPS; k++) begin
                acc[k] <= '0;
            end
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int k = 0; k < TAPS; k++) begin
                    acc[k] <= pext[k] + carry[k];
                end
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping.
`ifdef FIR_SAT_EN
    localparam logic signed [AW:0] MAXV =
        {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV =
        {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
    logic clamp;
    logic sat_r;

    always_comb begin
        rsum  = {acc[0][AW-1], acc[0]} + RND;
        y     = rsum >>> SHIFT;
        clamp = 1'b0;
        y_fmt = y[DW-1:0];
        if (y > MAXV) begin
            y_fmt = {1'b0, {(DW-1){1'b1}}};
            clamp = 1'b1;
        end else if (y < MINV) begin
            y_fmt = {1'b1, {(DW-1){1'b0}}};
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (!bus.flush && v2 && clamp) begin
            sat_r <= 1'b1;
        end
    end

    assign bus.sat_flag = sat_r;
`else
    logic unused_y;

    always_comb begin
        rsum  = {acc[0][AW-1], acc[0]} + RND;
        y     = rsum >>> SHIFT;
        y_fmt = y[DW-1:0];
    end

    assign unused_y     = ^y[AW:DW];
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r <= '0;
            dv_r   <= 1'b0;
        end else if (bus.flush) begin
            dv_r   <= 1'b0;
        end else begin
            dv_r <= v2;
            if (v2) begin
                dout_r <= y_fmt;
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dv_r;
endmodule

// File: tb/tb_fir_transposed_pipe.sv
// tb_fir_transposed_pipe: directed checks of the transposed FIR.
// Three instances: TAPS=4 SHIFT=0, TAPS=4 SHIFT=15, TAPS=5 SHIFT=0.
module tb_fir_transposed_pipe;
    logic clk;
    logic rst;
    logic din_valid;
    logic flush;
    logic coef_wr;
    logic coef_commit;
    logic signed [15:0] din;
    logic signed [15:0] coef_data;
    logic [2:0] coef_addr;
    int total;
    int passed;
    int fails;
    int cyc;
    int c0;
    int q0[$];
    int t0[$];
    int q1[$];
    int q2[$];
    int ex[8];

    fir_transposed_pipe_if #(.TAPS(4), .DW(16), .CW(16)) i0 ();
    fir_transposed_pipe_if #(.TAPS(4), .DW(16), .CW(16)) i1 ();
    fir_transposed_pipe_if #(.TAPS(5), .DW(16), .CW(16)) i2 ();

    assign i0.din_valid   = din_valid;
    assign i0.din         = din;
    assign i0.flush       = flush;
    assign i0.coef_wr     = coef_wr & ~coef_addr[2];
    assign i0.coef_addr   = coef_addr[1:0];
    assign i0.coef_data   = coef_data;
    assign i0.coef_commit = coef_commit;
    assign i1.din_valid   = din_valid;
    assign i1.din         = din;
    assign i1.flush       = flush;
    assign i1.coef_wr     = coef_wr & ~coef_addr[2];
    assign i1.coef_addr   = coef_addr[1:0];
    assign i1.coef_data   = coef_data;
    assign i1.coef_commit = coef_commit;
    assign i2.din_valid   = din_valid;
    assign i2.din         = din;
    assign i2.flush       = flush;
    assign i2.coef_wr     = coef_wr;
    assign i2.coef_addr   = coef_addr;
    assign i2.coef_data   = coef_data;
    assign i2.coef_commit = coef_commit;

    fir_transposed_pipe #(.TAPS(4), .DW(16), .CW(16), .SHIFT(0))
        u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    fir_transposed_pipe #(.TAPS(4), .DW(16), .CW(16), .SHIFT(15))
        u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    fir_transposed_pipe #(.TAPS(5), .DW(16), .CW(16), .SHIFT(0))
        u2 (.clk(clk), .rst(rst), .bus(i2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, need %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (i0.dout_valid) begin
            q0.push_back(int'(i0.dout));
            t0.push_back(cyc);
        end
        if (i1.dout_valid) q1.push_back(int'(i1.dout));
        if (i2.dout_valid) q2.push_back(int'(i2.dout));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearq();
        q0.delete();
        t0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic feed(input int v);
        din_valid = 1'b1;
        din = 16'(v);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wrc(input int a, input int d);
        coef_wr = 1'b1;
        coef_addr = 3'(a);
        coef_data = 16'(d);
        tick();
        coef_wr = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic load4(input int a, input int b,
                         input int c, input int d);
        wrc(0, a);
        wrc(1, b);
        wrc(2, c);
        wrc(3, d);
        commit();
    endtask

    task automatic chk_q(input string tag, input int which,
                         input int n, input int e[8]);
        int g[$];
        case (which)
            0: g = q0;
            1: g = q1;
            default: g = q2;
        endcase
        chk({tag, "_cnt"}, g.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d", tag, i),
                (g.size() > i) ? g[i] : -999999, e[i]);
        end
    endtask

    function automatic int tgap(input int i);
        return (t0.size() > i) ? t0[i] - t0[i-1] : -1;
    endfunction

    function automatic int tlat();
        return (t0.size() > 0) ? t0[0] - c0 : -1;
    endfunction

    initial begin
        total = 0;
        passed = 0;
        fails = 0;
        cyc = 0;
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        flush = 1'b0;
        coef_wr = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        coef_commit = 1'b0;
        idle(2);
        chk("rst_dout", i0.dout, 0);
        chk("rst_dv", i0.dout_valid, 0);
        chk("rst_sat", i1.sat_flag, 0);
        rst = 1'b0;

        // impulse, back-to-back
        clearq();
        load4(1, 2, 3, 4);
        c0 = cyc;
        feed(1); feed(0); feed(0); feed(0);
        idle(4);
        ex = '{1, 2, 3, 4, 0, 0, 0, 0};
        chk_q("imp", 0, 4, ex);
        chk("imp_lat", tlat(), 3);
        for (int i = 1; i < 4; i++) chk("imp_gap", tgap(i), 1);

        // impulse, one sample every 3rd cycle
        clearq();
        c0 = cyc;
        feed(1); idle(2);
        feed(0); idle(2);
        feed(0); idle(2);
        feed(0); idle(5);
        chk_q("gapd", 0, 4, ex);
        chk("gapd_lat", tlat(), 3);
        for (int i = 1; i < 4; i++) chk("gapd_gap", tgap(i), 3);

        // run-time reload while streaming ones
        din_valid = 1'b1;
        din = 16'sd1;
        idle(8);
        clearq();
        for (int a = 0; a < 4; a++) begin
            coef_wr = 1'b1;
            coef_addr = 3'(a);
            coef_data = 16'sd5;
            tick();
        end
        coef_wr = 1'b0;
        idle(4);
        ex = '{10, 10, 10, 10, 10, 10, 10, 10};
        chk_q("shadow", 0, 8, ex);
        clearq();
        commit();
        idle(7);
        ex = '{10, 10, 14, 17, 19, 20, 20, 20};
        chk_q("reload", 0, 8, ex);

        // asynchronous reset in the middle of the stream
        #3;
        rst = 1'b1;
        #1;
        chk("arst_dout", i0.dout, 0);
        chk("arst_dv", i0.dout_valid, 0);
        chk("arst_sat", i0.sat_flag, 0);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        clearq();
        c0 = cyc;
        feed(1000);
        idle(5);
        ex = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_q("arst_act", 0, 1, ex);
        chk("arst_lat", tlat(), 3);
        commit();
        clearq();
        feed(1000);
        idle(5);
        chk_q("arst_shd", 0, 1, ex);

        // rounding and overflow, SHIFT=15
        load4(16384, 0, 0, 0);
        clearq();
        feed(32767);
        idle(4);
        ex = '{16384, 0, 0, 0, 0, 0, 0, 0};
        chk_q("round", 1, 1, ex);
        load4(32767, 32767, 32767, 32767);
        clearq();
        din_valid = 1'b1;
        din = 16'sd32767;
        idle(8);
        din_valid = 1'b0;
        idle(4);
`ifdef FIR_SAT_EN
        ex = '{32766, 32767, 32767, 32767,
               32767, 32767, 32767, 32767};
        chk_q("ovf", 1, 8, ex);
        chk("ovf_sat", i1.sat_flag, 1);
`else
        ex = '{32766, -4, 32762, -8, -8, -8, -8, -8};
        chk_q("ovf", 1, 8, ex);
        chk("ovf_sat", i1.sat_flag, 0);
`endif

        // flush beats a same-cycle sample
        clearq();
        flush = 1'b1;
        din_valid = 1'b1;
        din = 16'sd7;
        tick();
        flush = 1'b0;
        din_valid = 1'b0;
        idle(5);
        chk("flush_cnt", q0.size(), 0);
`ifdef FIR_SAT_EN
        chk("flush_dout", i0.dout, 32767);
        chk("flush_sat", i1.sat_flag, 1);
`else
        chk("flush_dout", i0.dout, 4);
        chk("flush_sat", i1.sat_flag, 0);
`endif
        load4(1, 2, 3, 4);
        clearq();
        c0 = cyc;
        feed(1); feed(0); feed(0); feed(0);
        idle(4);
        ex = '{1, 2, 3, 4, 0, 0, 0, 0};
        chk_q("fimp", 0, 4, ex);
        chk("fimp_lat", tlat(), 3);
        for (int i = 1; i < 4; i++) chk("fimp_gap", tgap(i), 1);

        // out-of-range coefficient address, TAPS=5
        wrc(5, 9);
        commit();
        clearq();
        feed(1); feed(0); feed(0); feed(0); feed(0);
        idle(4);
        ex = '{1, 2, 3, 4, 0, 0, 0, 0};
        chk_q("addr", 2, 5, ex);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
